// File: rtl/galvo_point_streamer.sv
// galvo_point_streamer: streams point RAM words to a dual 12-bit SPI DAC, latches them and drives laser enables
module galvo_point_streamer #(
   parameter int CLK_DIV = 4,
   parameter int ADDR_W  = 10,
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               loop_en,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic [DWELL_W-1:0] dwell,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [31:0]        mem_dout,
   output logic               busy,
   output logic               frame_done,
   output logic               dac_csn,
   output logic               dac_sclk,
   output logic               dac_mosi,
   output logic               dac_latchn,
   output logic [2:0]         laser_rgb
);
   localparam int CW = $clog2(2*CLK_DIV+3);
   localparam logic [CW-1:0] SUB_LAST = CW'(CLK_DIV-1);
   localparam logic [CW-1:0] LAT_LOW  = CW'(CLK_DIV);
   localparam logic [CW-1:0] LAT_LAST = CW'(2*CLK_DIV+1);
   typedef enum logic [3:0] {IDLE, FETCH, WAIT, SEND_X, GAP, SEND_Y, GAP2, LATCH, DWELL} state_t;
   state_t state, nxt;
   logic [CW-1:0] cnt;
   logic hi;
   logic [3:0] bit_n;
   logic [DWELL_W-1:0] dcnt;
   logic [31:0] point;
   logic [15:0] frame;
   logic send, last_sub, send_end, dwell_end;
   logic unused_bits;
   assign unused_bits = ^point[30:27];
   // state register; reset and stop both land in IDLE
   always_ff @(posedge clk) begin
      state <= !reset ? IDLE : nxt;
   end
   // next-state decode and outputs decoded from state so IDLE always shows reset values
   always_comb begin
      send      = state == SEND_X || state == SEND_Y;
      last_sub  = cnt == SUB_LAST;
      send_end  = send && hi && last_sub && bit_n == 4'hF;
      dwell_end = state == DWELL && dcnt == DWELL_W'(1);
      frame     = state == SEND_Y ? {4'b1011, point[11:0]} : {4'b0011, point[23:12]};
      nxt       = state;
      case (state)
         IDLE:    nxt = start ? FETCH : IDLE;
         FETCH:   nxt = WAIT;
         WAIT:    nxt = SEND_X;
         SEND_X:  nxt = send_end ? GAP : SEND_X;
         GAP:     nxt = last_sub ? SEND_Y : GAP;
         SEND_Y:  nxt = send_end ? GAP2 : SEND_Y;
         GAP2:    nxt = last_sub ? LATCH : GAP2;
         LATCH:   nxt = cnt == LAT_LAST ? DWELL : LATCH;
         DWELL:   nxt = !dwell_end ? DWELL : point[31] && !loop_en ? IDLE : FETCH;
         default: nxt = IDLE;
      endcase
      if (stop) nxt = IDLE;
      busy       = state != IDLE;
      frame_done = dwell_end && point[31];
      dac_csn    = !send;
      dac_sclk   = send && hi;
      dac_mosi   = send && frame[4'hF - bit_n];
      dac_latchn = !(state == LATCH && cnt < LAT_LOW);
   end
   // datapath: phase/bit counters, point capture, dwell timer, address and colour
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt       <= '0;
         hi        <= 1'b0;
         bit_n     <= '0;
         point     <= '0;
         dcnt      <= '0;
         laser_rgb <= '0;
         mem_addr  <= '0;
      end else begin
         cnt       <= nxt != state || (send && last_sub) ? '0 : cnt + CW'(1);
         hi        <= send && nxt == state ? hi ^ last_sub : 1'b0;
         bit_n     <= send && nxt == state ? bit_n + 4'(hi && last_sub) : 4'h0;
         point     <= state == WAIT ? mem_dout : point;
         dcnt      <= state == LATCH ? (dwell == '0 ? DWELL_W'(1) : dwell) : state == DWELL ? dcnt - DWELL_W'(1) : dcnt;
         laser_rgb <= nxt == IDLE ? 3'b000 : state == LATCH && last_sub ? point[26:24] : laser_rgb;
         mem_addr  <= nxt == IDLE ? '0 : state == IDLE || (dwell_end && point[31]) ? base_addr : dwell_end ? mem_addr + ADDR_W'(1) : mem_addr;
      end
   end
endmodule
